apb_master_interface: RTL and testbench
=======================================

// Module: apb_master_interface
// PURPOSE
//  APB initiator for the APB-to-SPI bridge. Turns a simple valid/ready command stream into
//  APB3 SETUP/ACCESS transfers toward the bridge's APB slave register file. Returns read
//  data and error status on a one-cycle response strobe.
//  Used as the host-side driver in system sims and as a reusable in-chip APB requester.
// PARAMETERS
//  ADDR_W   3   APB address width (SPI register map: 3 bits)
//  DATA_W   8   APB data width
//  TIMEOUT  16  max ACCESS cycles waiting for PREADY; 0 = wait forever
// PORTS
//  PCLK         in   1       APB clock; all logic on rising edge
//  PRESET_n     in   1       async active-low reset
//  cmd_valid_i  in   1       command request
//  cmd_ready_o  out  1       command accepted when valid&ready at PCLK edge
//  cmd_write_i  in   1       1=write, 0=read
//  cmd_addr_i   in   ADDR_W  target register address
//  cmd_wdata_i  in   DATA_W  write data
//  rsp_valid_o  out  1       one-cycle pulse: transfer finished
//  rsp_rdata_o  out  DATA_W  read data (0 for writes/timeout)
//  rsp_err_o    out  1       PSLVERR sampled at completion, or timeout
//  PADDR_o      out  ADDR_W  APB address
//  PWRITE_o     out  1       APB direction
//  PSEL_o       out  1       APB select
//  PENABLE_o    out  1       APB enable
//  PWDATA_o     out  DATA_W  APB write data
//  PRDATA_i     in   DATA_W  APB read data
//  PREADY_i     in   1       slave ready
//  PSLVERR_i    in   1       slave error
// BEHAVIOUR
//  Reset: state IDLE; PSEL/PENABLE/PWRITE/PADDR/PWDATA=0; rsp_valid/rsp_err=0; rsp_rdata=0;
//   wait counter=0. Async assert, sync release. Reset mid-transfer aborts, no rsp pulse.
//  All APB outputs and rsp_* are registered; cmd_ready_o = (state==IDLE), combinational.
//  FSM: IDLE -> SETUP on cmd_valid&cmd_ready; capture addr/write/wdata into PADDR/PWRITE/
//   PWDATA; PSEL=1, PENABLE=0.
//   SETUP -> ACCESS unconditionally after one cycle; PENABLE=1, counter cleared.
//   ACCESS with PREADY=1: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR_i,
//   rsp_rdata = PWRITE ? 0 : PRDATA_i; -> IDLE.
//   ACCESS with PREADY=0: hold all APB signals stable, counter++.
//   If TIMEOUT!=0 and counter==TIMEOUT-1 with PREADY=0: end transfer as above, rsp_err=1,
//   rsp_rdata=0.
//  Latency: accept at edge N -> SETUP N..N+1 -> ACCESS from N+1; zero-wait slave gives
//   rsp_valid high in cycle after edge N+2 (accept-to-rsp = 2 cycles + wait states).
//  Back-to-back: cmd_ready high again in rsp_valid cycle; new SETUP starts same edge that
//   rsp_valid drops, so PSEL deasserts for exactly one cycle between transfers.
//  PADDR/PWRITE/PWDATA hold last values in IDLE; PWDATA updated on reads too (don't care).
//  rsp_valid/rsp_err self-clear next cycle; rsp_rdata holds until next completion.
//  Counter width = clog2(TIMEOUT)+1; saturates, never wraps.
//  cmd_* ignored outside IDLE; PSLVERR/PRDATA ignored unless ACCESS&PREADY.
// TESTING
//  1 reset, write(0,0xAA), PREADY=1 -> PSEL 2 cyc, PENABLE 1 cyc, PWDATA=0xAA, rsp_err=0
//  2 read(1), slave PRDATA=0xBD zero-wait -> rsp_valid 1 cyc, rsp_rdata=0xBD, err=0
//  3 read(2), PREADY low 3 ACCESS cycles, PRDATA=0xFF -> APB stable, rsp at accept+5
//  4 write(3,0x55) with PSLVERR=1 at PREADY -> rsp_err=1, rsp_rdata=0, back to IDLE
//  5 TIMEOUT=16, PREADY stuck 0 -> rsp_valid+rsp_err after 16 ACCESS cycles, PSEL=0
//  6 PRESET_n low mid-ACCESS -> all outputs 0 at once, no rsp_valid; next cmd runs normal

Source files
------------

// File: rtl/apb_master_interface_if.sv
// rtl/apb_master_interface_if.sv - command/response stream and APB3 bus bundle for the APB requester
interface apb_master_interface_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_master_interface.sv
// rtl/apb_master_interface.sv - APB3 requester turning a valid/ready command stream into SETUP/ACCESS transfers
module apb_master_interface #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET_n,
    apb_master_interface_if.master  bus
);
    // Counter is one bit wider than needed for TIMEOUT-1 so it can saturate when TIMEOUT=0.
    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam bit                TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic              psel_q;
    logic              penable_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Transfer sequencer: IDLE accepts a command, SETUP lasts one cycle, ACCESS waits for PREADY or timeout.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr_q   <= bus.cmd_addr;
                        pwrite_q  <= bus.cmd_write;
                        pwdata_q  <= bus.cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        state       <= ST_IDLE;
                    end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state       <= ST_IDLE;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_interface.sv
// tb/tb_apb_master_interface.sv - scoreboard bench for the APB requester with a randomized APB slave model
module tb_apb_master_interface;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                lat;
        int                acc;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
        int                w;
        logic [DATA_W-1:0] d;
        logic              e;
    } slv_t;

    logic PCLK;
    logic PRESET_n;
    int   tests;
    int   fails;
    int   cyc;

    exp_t exp_q[$];
    slv_t slv_q[$];

    apb_master_interface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .bus      (bus)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge PCLK);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got %0d cycles limit %0d", cyc, 30000);
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: completion rule from the slave's wait count, independent of any FSM detail.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input int w, input logic [DATA_W-1:0] d, input logic e);
        int   guard;
        exp_t x;
        slv_t s;
        guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        while (!bus.cmd_ready) begin
            @(negedge PCLK);
            guard++;
            if (guard > 200) begin
                chk(1'b0, "cmd_ready_wait", 0, 1);
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        if (w >= TIMEOUT) begin
            x.rdata = '0;
            x.err   = 1'b1;
            x.lat   = TIMEOUT + 1;
        end else begin
            x.rdata = wr ? '0 : d;
            x.err   = e;
            x.lat   = w + 2;
        end
        x.acc = cyc + 1;
        exp_q.push_back(x);
        s.addr = a; s.wr = wr; s.wdata = wd; s.w = w; s.d = d; s.e = e;
        slv_q.push_back(s);
        @(posedge PCLK);
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = ADDR_W'($urandom);
        bus.cmd_wdata = DATA_W'($urandom);
    endtask

    // Slave model: checks the APB request and answers after the chosen number of wait states.
    initial begin
        slv_t cur;
        int   k;
        bit   active;
        active = 1'b0;
        k = 0;
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESET_n) begin
                active = 1'b0;
                bus.pready = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                if (slv_q.size() == 0) begin
                    chk(1'b0, "unexpected_setup", 1, 0);
                    active = 1'b0;
                end else begin
                    cur = slv_q.pop_front();
                    active = 1'b1;
                    k = 0;
                    chk(bus.paddr == cur.addr, "setup_paddr", int'(bus.paddr), int'(cur.addr));
                    chk(bus.pwrite == cur.wr, "setup_pwrite", int'(bus.pwrite), int'(cur.wr));
                    if (cur.wr)
                        chk(bus.pwdata == cur.wdata, "setup_pwdata", int'(bus.pwdata), int'(cur.wdata));
                end
                bus.pready  = 1'($urandom);
                bus.prdata  = DATA_W'($urandom);
                bus.pslverr = 1'($urandom);
            end else if (bus.psel && bus.penable && active) begin
                chk(bus.paddr == cur.addr, "access_paddr", int'(bus.paddr), int'(cur.addr));
                chk(bus.pwrite == cur.wr, "access_pwrite", int'(bus.pwrite), int'(cur.wr));
                if (cur.wr)
                    chk(bus.pwdata == cur.wdata, "access_pwdata", int'(bus.pwdata), int'(cur.wdata));
                if (k == cur.w) begin
                    bus.pready  = 1'b1;
                    bus.prdata  = cur.d;
                    bus.pslverr = cur.e;
                end else begin
                    bus.pready  = 1'b0;
                    bus.prdata  = DATA_W'($urandom);
                    bus.pslverr = 1'($urandom);
                end
                k++;
            end else begin
                bus.pready  = 1'($urandom);
                bus.prdata  = DATA_W'($urandom);
                bus.pslverr = 1'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard on each response strobe and checks data, status, latency and bus shape.
    initial begin
        exp_t x;
        int   psel_run;
        int   pen_run;
        logic [DATA_W-1:0] last_rdata;
        psel_run = 0;
        pen_run = 0;
        last_rdata = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESET_n) begin
                psel_run = 0;
                pen_run = 0;
                last_rdata = '0;
            end else begin
                if (bus.psel) psel_run++;
                if (bus.penable) pen_run++;
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_rsp", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk(bus.rsp_rdata == x.rdata, "rsp_rdata", int'(bus.rsp_rdata), int'(x.rdata));
                        chk(bus.rsp_err == x.err, "rsp_err", int'(bus.rsp_err), int'(x.err));
                        chk((cyc - x.acc) == x.lat, "rsp_latency", cyc - x.acc, x.lat);
                        chk(psel_run == x.lat, "psel_cycles", psel_run, x.lat);
                        chk(pen_run == x.lat - 1, "penable_cycles", pen_run, x.lat - 1);
                        chk(!bus.psel && !bus.penable, "idle_at_rsp", int'({bus.psel, bus.penable}), 0);
                        chk(bus.cmd_ready, "ready_at_rsp", int'(bus.cmd_ready), 1);
                        last_rdata = x.rdata;
                    end
                    psel_run = 0;
                    pen_run = 0;
                end else begin
                    chk(bus.rsp_rdata == last_rdata, "rdata_hold", int'(bus.rsp_rdata), int'(last_rdata));
                    chk(!bus.rsp_err, "err_idle", int'(bus.rsp_err), 0);
                end
            end
        end
    end

    initial begin
        int guard;
        int w;
        int r;
        tests = 0;
        fails = 0;
        PRESET_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge PCLK);
        chk({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} == '0, "reset_apb", 
            int'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 0);
        chk({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} == '0, "reset_rsp",
            int'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
        chk(bus.cmd_ready, "reset_ready", int'(bus.cmd_ready), 1);
        PRESET_n = 1'b1;
        @(negedge PCLK);

        issue(1'b1, 3'd0, 8'hAA, 0, 8'h11, 1'b0);
        issue(1'b0, 3'd1, 8'h00, 0, 8'hBD, 1'b0);
        issue(1'b0, 3'd2, 8'h00, 3, 8'hFF, 1'b0);
        issue(1'b1, 3'd3, 8'h55, 0, 8'h99, 1'b1);
        issue(1'b0, 3'd4, 8'h00, 40, 8'h77, 1'b0);
        repeat (25) @(negedge PCLK);

        issue(1'b0, 3'd5, 8'h00, 10, 8'h3C, 1'b0);
        repeat (3) @(negedge PCLK);
        #3 PRESET_n = 1'b0;
        #1;
        chk({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} == '0, "midreset_apb",
            int'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 0);
        chk({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} == '0, "midreset_rsp",
            int'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
        chk(bus.cmd_ready, "midreset_ready", int'(bus.cmd_ready), 1);
        exp_q.delete();
        slv_q.delete();
        repeat (2) @(negedge PCLK);
        PRESET_n = 1'b1;
        repeat (6) @(negedge PCLK);
        issue(1'b0, 3'd6, 8'h00, 1, 8'hC3, 1'b0);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom % 3) @(negedge PCLK);
            r = int'($urandom % 10);
            if (r < 7)      w = int'($urandom % 4);
            else if (r < 9) w = int'($urandom_range(8, 4));
            else            w = int'($urandom_range(24, 16));
            issue(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), w,
                  DATA_W'($urandom), ($urandom % 4) == 0);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        repeat (4) @(negedge PCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
